decode_queue: RTL and testbench

Registered, multi-thread decode stage for the ThreadKraken pipeline. It accepts one 32-bit instruction per cycle tagged with a hardware-thread ID and decodes it into a packed control bundle. The result is buffered in a DEPTH-entry in-order queue with valid/ready handshakes on both sides. It adds per-thread flush, so a killed or sleeping thread's in-flight decodes are discarded, and per-thread saturating invalid-instruction counters. It sits between fetch and register read/execute.

---
 rtl/kraken_dec_pkg.sv | 51 +++++
 rtl/decode_core.sv | 69 ++++++
 rtl/decode_queue.sv | 101 ++++++++++
 tb/tb_decode_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/kraken_dec_pkg.sv
// Shared types and encodings for the ThreadKraken decode stage.
package kraken_dec_pkg;

    // Major opcodes, carried in ins[4:1]
    localparam logic [3:0] OP_CAL    = 4'd0;
    localparam logic [3:0] OP_SHIFT  = 4'd1;
    localparam logic [3:0] OP_CALI   = 4'd2;
    localparam logic [3:0] OP_LOADI  = 4'd3;
    localparam logic [3:0] OP_MEMOP  = 4'd4;
    localparam logic [3:0] OP_BRANCH = 4'd5;
    localparam logic [3:0] OP_EXC    = 4'd6;
    localparam logic [3:0] OP_MULTI  = 4'd7;

    // Jump/branch condition encodings
    localparam logic [3:0] JMP_NONE = 4'b0000;
    localparam logic [3:0] JMP_LINK = 4'b0111;
    localparam logic [3:0] JMP_REGL = 4'b1111;
    localparam logic [3:0] JMP_EQ   = 4'b0001;
    localparam logic [3:0] JMP_NE   = 4'b0100;
    localparam logic [3:0] JMP_LT   = 4'b0010;

    // Memory access encodings
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // Thread control encodings
    localparam logic [1:0] TRD_NONE  = 2'b00;
    localparam logic [1:0] TRD_SLEEP = 2'b01;
    localparam logic [1:0] TRD_WAKE  = 2'b10;
    localparam logic [1:0] TRD_KILL  = 2'b11;

    typedef struct packed {
        logic [4:0]  reg_rd_a;
        logic [4:0]  reg_rd_b;
        logic [4:0]  reg_wr;
        logic [15:0] imm;
        logic        wr_en;
        logic [2:0]  alu_op;
        logic [1:0]  mem_ctrl;
        logic [1:0]  trd_ctrl;
        logic        wb_sel;
        logic        init;
        logic        exp_jmp;
        logic        exp_return;
        logic [3:0]  jmp_con;
        logic        invalid;
        logic        i_type;
    } dec_t;

endpackage

// File: rtl/decode_core.sv
// Pure combinational instruction decoder: 32-bit word to control bundle.
module decode_core
    import kraken_dec_pkg::*;
(
    input  logic [31:0] ins,
    output dec_t        dec
);

    logic [3:0] op;
    logic [2:0] funct;
    logic       unused_bits;

    assign op          = ins[4:1];
    assign funct       = ins[7:5];
    assign unused_bits = ^{ins[9], ins[0]};

    // Register fields are raw slices; control fields default to 0 and are set per opcode
    always_comb begin
        dec          = '0;
        dec.reg_rd_a = ins[26:22];
        dec.reg_rd_b = (op == OP_BRANCH || op == OP_MEMOP) ? ins[31:27] : ins[21:17];
        dec.reg_wr   = ins[31:27];
        dec.imm      = ins[25:10];
        dec.alu_op   = ins[7:5];
        case (op)
            OP_CAL, OP_SHIFT: dec.wr_en = 1'b1;
            OP_CALI, OP_LOADI: begin
                dec.wr_en  = 1'b1;
                dec.i_type = 1'b1;
            end
            OP_MEMOP: begin
                dec.i_type = 1'b1;
                if (ins[8]) begin
                    dec.mem_ctrl = MEM_READ;
                    dec.wr_en    = 1'b1;
                    dec.wb_sel   = 1'b1;
                end else begin
                    dec.mem_ctrl = MEM_WRITE;
                end
            end
            OP_BRANCH: begin
                case (funct)
                    3'b000: begin dec.jmp_con = JMP_LINK; dec.wr_en = 1'b1; end
                    3'b010: begin dec.jmp_con = JMP_REGL; dec.wr_en = 1'b1; end
                    3'b001: dec.jmp_con = JMP_EQ;
                    3'b011: dec.jmp_con = JMP_NE;
                    3'b111: dec.jmp_con = JMP_LT;
                    default: dec.invalid = 1'b1;
                endcase
            end
            OP_EXC: begin
                if (ins[5])      dec.exp_jmp    = 1'b1;
                else if (ins[6]) dec.exp_return = 1'b1;
                else             dec.invalid    = 1'b1;
            end
            OP_MULTI: begin
                case (funct)
                    3'b111: begin dec.wr_en = 1'b1; dec.init = 1'b1; end
                    3'b101: dec.trd_ctrl = TRD_SLEEP;
                    3'b010: dec.trd_ctrl = TRD_WAKE;
                    3'b000: dec.trd_ctrl = TRD_KILL;
                    default: dec.invalid = 1'b1;
                endcase
            end
            default: dec.invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Multi-thread decode stage: decodes, queues in order, supports per-thread
// flush and keeps saturating per-thread invalid-instruction counters.
module decode_queue
    import kraken_dec_pkg::*;
#(
    parameter  int NUM_THREAD = 4,
    parameter  int DEPTH      = 2,
    parameter  int CNT_W      = 16,
    localparam int TID_W      = $clog2(NUM_THREAD)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_vld,
    output logic                                 in_rdy,
    input  logic [31:0]                          in_ins,
    input  logic [TID_W-1:0]                     in_tid,
    output logic                                 out_vld,
    input  logic                                 out_rdy,
    output logic [TID_W-1:0]                     out_tid,
    output dec_t                                 out_dec,
    input  logic                                 flush_vld,
    input  logic [TID_W-1:0]                     flush_tid,
    input  logic                                 inv_clr,
    output logic [NUM_THREAD-1:0][CNT_W-1:0]     inv_cnt
);

    localparam int             PW   = $clog2(DEPTH);
    localparam logic [PW:0]    FULL = (PW+1)'(DEPTH);

    dec_t             in_dec;
    dec_t             q_dec [DEPTH];
    logic [TID_W-1:0] q_tid [DEPTH];
    logic [DEPTH-1:0] q_ev;
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW:0]      count, count_nxt;
    logic             push, pop, push_ev, head_ev, head_flushed, nonempty;

    decode_core u_core (
        .ins (in_ins),
        .dec (in_dec)
    );

    assign nonempty     = (count != '0);
    assign in_rdy       = (count != FULL);
    assign head_ev      = q_ev[rd_ptr];
    assign out_vld      = nonempty & head_ev;
    assign out_tid      = q_tid[rd_ptr];
    assign out_dec      = q_dec[rd_ptr];
    assign head_flushed = flush_vld & (q_tid[rd_ptr] == flush_tid);
    assign push         = in_vld & in_rdy;
    assign push_ev      = ~(flush_vld & (in_tid == flush_tid));

    // A flushed head is never popped by the handshake; it drains one cycle later as a bubble
    always_comb begin
        pop       = nonempty & (head_ev ? (out_rdy & ~head_flushed) : 1'b1);
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + (PW+1)'(1);
            2'b01:   count_nxt = count - (PW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Queue storage, pointers and entry-valid bits, with flush invalidation
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_ev   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_dec[i] <= '0;
                q_tid[i] <= '0;
            end
        end else begin
            count <= count_nxt;
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (flush_vld) begin
                for (int i = 0; i < DEPTH; i++)
                    if (q_tid[i] == flush_tid) q_ev[i] <= 1'b0;
            end
            if (push) begin
                q_dec[wr_ptr] <= in_dec;
                q_tid[wr_ptr] <= in_tid;
                q_ev[wr_ptr]  <= push_ev;
                wr_ptr        <= wr_ptr + PW'(1);
            end
        end
    end

    // Saturating invalid counters; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || inv_clr) begin
            inv_cnt <= '0;
        end else if (push && push_ev && in_dec.invalid) begin
            if (inv_cnt[in_tid] != '1)
                inv_cnt[in_tid] <= inv_cnt[in_tid] + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (NUM_THREAD=4, DEPTH=2, CNT_W=2).
module tb_decode_queue;
    import kraken_dec_pkg::*;

    logic             clk = 1'b0;
    logic             rst, in_vld, in_rdy, out_vld, out_rdy, flush_vld, inv_clr;
    logic [31:0]      in_ins;
    logic [1:0]       in_tid, out_tid, flush_tid;
    dec_t             out_dec;
    logic [3:0][1:0]  inv_cnt;

    int total = 0;
    int bad   = 0;

    decode_queue #(.NUM_THREAD(4), .DEPTH(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_ins(in_ins),
        .in_tid(in_tid), .out_vld(out_vld), .out_rdy(out_rdy), .out_tid(out_tid),
        .out_dec(out_dec), .flush_vld(flush_vld), .flush_tid(flush_tid),
        .inv_clr(inv_clr), .inv_cnt(inv_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    dec_t        e, ea, eb;
    logic [31:0] tins [7];
    dec_t        texp [7];

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_ins = '0; in_tid = '0; out_rdy = 1'b0;
        flush_vld = 1'b0; flush_tid = '0; inv_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_rdy",  64'(in_rdy),  64'd1);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_out_tid", 64'(out_tid), 64'd0);
        check("rst_out_dec", 64'(out_dec), 64'd0);
        check("rst_inv_cnt", 64'(inv_cnt), 64'd0);

        // CALI on tid 2, no bypass into an empty queue
        e = '0; e.reg_rd_a = 5'd8; e.reg_rd_b = 5'h1A; e.reg_wr = 5'd2; e.imm = 16'h8D15;
        e.wr_en = 1'b1; e.alu_op = 3'd1; e.i_type = 1'b1;
        in_vld = 1'b1; in_ins = 32'h1234_5624; in_tid = 2'd2;
        #1 check("nobypass_vld", 64'(out_vld), 64'd0);
        tick();
        in_vld = 1'b0;
        check("cali_vld", 64'(out_vld), 64'd1);
        check("cali_tid", 64'(out_tid), 64'd2);
        check("cali_dec", 64'(out_dec), 64'(e));
        out_rdy = 1'b1;
        tick();
        out_rdy = 1'b0;
        check("cali_popped", 64'(out_vld), 64'd0);

        // Fill to DEPTH with consumer stalled, then drain in order
        ea = '0; ea.reg_rd_b = 5'd31; ea.reg_wr = 5'd31; ea.wr_en = 1'b1;
        ea.mem_ctrl = MEM_READ; ea.wb_sel = 1'b1; ea.i_type = 1'b1;
        eb = '0; eb.alu_op = 3'd7; eb.wr_en = 1'b1; eb.init = 1'b1;
        in_vld = 1'b1; in_ins = 32'hF800_0108; in_tid = 2'd1;
        tick();
        check("fill1_in_rdy", 64'(in_rdy), 64'd1);
        in_ins = 32'h0000_00EE; in_tid = 2'd0;
        tick();
        in_vld = 1'b0;
        check("fill2_in_rdy", 64'(in_rdy), 64'd0);
        tick();
        check("stall_tid", 64'(out_tid), 64'd1);
        check("stall_dec", 64'(out_dec), 64'(ea));
        out_rdy = 1'b1;
        tick();
        check("drain1_in_rdy", 64'(in_rdy), 64'd1);
        check("drain1_tid", 64'(out_tid), 64'd0);
        check("drain1_dec", 64'(out_dec), 64'(eb));
        tick();
        check("drain2_vld", 64'(out_vld), 64'd0);
        out_rdy = 1'b0;

        // Flush tid 1 with queue holding {1,0}
        in_vld = 1'b1; in_ins = 32'h0000_0000; in_tid = 2'd1;
        tick();
        in_ins = 32'h0000_0002; in_tid = 2'd0;
        tick();
        in_vld = 1'b0;
        flush_vld = 1'b1; flush_tid = 2'd1; out_rdy = 1'b1;
        check("flush_head_vld", 64'(out_vld), 64'd1);
        tick();
        flush_vld = 1'b0;
        check("flush_bubble", 64'(out_vld), 64'd0);
        tick();
        check("flush_keep_vld", 64'(out_vld), 64'd1);
        check("flush_keep_tid", 64'(out_tid), 64'd0);
        tick();
        check("flush_empty", 64'(out_vld), 64'd0);
        out_rdy = 1'b0;

        // Same-cycle push under flush is stored dead and does not count
        in_vld = 1'b1; in_ins = 32'h0000_001E; in_tid = 2'd3;
        flush_vld = 1'b1; flush_tid = 2'd3;
        tick();
        in_vld = 1'b0; flush_vld = 1'b0;
        check("flushpush_vld", 64'(out_vld), 64'd0);
        check("flushpush_cnt", 64'(inv_cnt[3]), 64'd0);
        tick();
        check("flushpush_drop", 64'(out_vld), 64'd0);

        // Decode table, each pushed on tid 1 and consumed immediately
        tins[0] = 32'h0000_00AE; texp[0] = '0; texp[0].alu_op = 3'd5; texp[0].trd_ctrl = TRD_SLEEP;
        tins[1] = 32'h0000_002C; texp[1] = '0; texp[1].alu_op = 3'd1; texp[1].exp_jmp = 1'b1;
        tins[2] = 32'h0000_004C; texp[2] = '0; texp[2].alu_op = 3'd2; texp[2].exp_return = 1'b1;
        tins[3] = 32'h0800_000A; texp[3] = '0; texp[3].reg_rd_b = 5'd1; texp[3].reg_wr = 5'd1;
        texp[3].jmp_con = JMP_LINK; texp[3].wr_en = 1'b1;
        tins[4] = 32'h0000_001E; texp[4] = '0; texp[4].invalid = 1'b1;
        tins[5] = 32'h0000_0008; texp[5] = '0; texp[5].i_type = 1'b1; texp[5].mem_ctrl = MEM_WRITE;
        tins[6] = 32'h0000_00EA; texp[6] = '0; texp[6].alu_op = 3'd7; texp[6].jmp_con = JMP_LT;
        out_rdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_vld = 1'b1; in_ins = tins[i]; in_tid = 2'd1;
            tick();
            in_vld = 1'b0;
            check($sformatf("tbl%0d_dec", i), 64'(out_dec), 64'(texp[i]));
            tick();
        end

        // Three invalid BRANCH funct 100 on tid 3, back to back
        in_vld = 1'b1; in_ins = 32'h0000_008A; in_tid = 2'd3;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("br%0d_invalid", i), 64'(out_dec.invalid), 64'd1);
            check($sformatf("br%0d_cnt", i), 64'(inv_cnt[3]), 64'(i));
        end
        in_vld = 1'b0;
        tick();
        inv_clr = 1'b1;
        tick();
        inv_clr = 1'b0;
        check("clr_cnt", 64'(inv_cnt), 64'd0);

        // Clear beats a same-cycle increment
        in_vld = 1'b1; inv_clr = 1'b1;
        tick();
        in_vld = 1'b0; inv_clr = 1'b0;
        check("clr_prio", 64'(inv_cnt[3]), 64'd0);
        tick();

        // Saturation on tid 0
        in_vld = 1'b1; in_ins = 32'h0000_001E; in_tid = 2'd0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("sat%0d", i), 64'(inv_cnt[0]), (i < 3) ? 64'(i) : 64'd3);
        end
        in_vld = 1'b0;
        tick();

        // Reset mid-operation with two entries queued
        out_rdy = 1'b0;
        in_vld = 1'b1; in_ins = 32'h1234_5624; in_tid = 2'd2;
        tick(); tick();
        check("pre_rst_full", 64'(in_rdy), 64'd0);
        rst = 1'b1;
        tick();
        check("mrst_out_vld", 64'(out_vld), 64'd0);
        check("mrst_in_rdy",  64'(in_rdy),  64'd1);
        check("mrst_out_dec", 64'(out_dec), 64'd0);
        check("mrst_inv_cnt", 64'(inv_cnt), 64'd0);
        rst = 1'b0; in_vld = 1'b0;
        tick();
        check("post_rst_vld", 64'(out_vld), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
